// File: rtl/ringosc_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized ro_in rising edges over a
// programmable window of 2^(gate_sel+4) clk cycles and reports a saturating count.
module ringosc_freq_meter #(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_in,
    input  logic             start,
    input  logic [3:0]       gate_sel,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int unsigned TMR_W = 20;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   edge_det;
    logic [3:0]             gsel;
    logic [TMR_W-1:0]       timer;
    logic [TMR_W-1:0]       window_last;
    logic [4:0]             shamt;
    logic [CNT_W-1:0]       work;
    logic [CNT_W-1:0]       work_nxt;
    logic                   sat;
    logic                   sat_nxt;

    // Plain flop chain into the clk domain, then a one-cycle history for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], ro_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign edge_det    = sync[SYNC_STAGES-1] & ~prev;
    assign shamt       = {1'b0, gsel} + 5'd4;
    assign window_last = (TMR_W'(1) << shamt) - TMR_W'(1);

    // Saturating increment; any attempt at full scale flags overflow
    always_comb begin
        work_nxt = work;
        sat_nxt  = sat;
        if (edge_det) begin
            if (work == CNT_MAX) begin
                sat_nxt = 1'b1;
            end else begin
                work_nxt = work + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gsel  <= '0;
            timer <= '0;
            work  <= '0;
            sat   <= 1'b0;
            count <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        gsel  <= gate_sel;
                        work  <= '0;
                        sat   <= 1'b0;
                        timer <= '0;
                        busy  <= 1'b1;
                        state <= ARM;
                    end
                end
                ARM: begin
                    // Let the synchronizer flush stale history before counting
                    if (timer == TMR_W'(SYNC_STAGES)) begin
                        timer <= '0;
                        state <= GATE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                GATE: begin
                    work <= work_nxt;
                    sat  <= sat_nxt;
                    if (timer == window_last) begin
                        count <= work_nxt;
                        ovf   <= sat_nxt;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Directed bench for ringosc_freq_meter: table of measurement vectors plus
// hand sequences for start re-pulsing, mid-gate reset and reset state.
module tb_ringosc_freq_meter;

    logic        clk;
    logic        rst;
    logic        ro_in;
    logic        start;
    logic [3:0]  gate_sel;
    logic [19:0] count;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  count_s;
    logic        busy_s;
    logic        done_s;
    logic        ovf_s;

    int nvec  = 0;
    int nfail = 0;
    int ro_half = 0;

    int   m_lat, m_busy;
    logic [19:0] m_cnt;
    logic [3:0]  m_cnt_s;
    logic m_ovf, m_ovf_s, m_post_done, m_post_busy;

    typedef struct {
        logic [3:0] g;
        logic [3:0] g_after;
        int         half;
        int         lo;
        int         hi;
        int         ovf;
        int         cs;
        int         os;
    } vec_t;

    vec_t vecs[7];

    ringosc_freq_meter dut (
        .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .gate_sel(gate_sel),
        .count(count), .busy(busy), .done(done), .ovf(ovf)
    );

    ringosc_freq_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut_s (
        .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .gate_sel(gate_sel),
        .count(count_s), .busy(busy_s), .done(done_s), .ovf(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ro_in source: toggles every ro_half cycles on the falling clk edge, held low when 0
    initial begin
        int ph;
        ph    = 0;
        ro_in = 1'b0;
        forever begin
            @(negedge clk);
            if (ro_half == 0) begin
                ro_in = 1'b0;
                ph    = 0;
            end else begin
                ph++;
                if (ph >= ro_half) begin
                    ro_in = ~ro_in;
                    ph    = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint lo, input longint hi);
        nvec++;
        if (act < lo || act > hi) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic set_ro(input int half);
        ro_half = half;
        repeat (12) @(negedge clk);
    endtask

    // One measurement; latency counted in cycles from the start-sampling edge to done
    task automatic run_meas(input logic [3:0] g, input logic [3:0] g_after, input bit release_rst);
        @(negedge clk);
        start    = 1'b1;
        gate_sel = g;
        if (release_rst) rst = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        gate_sel = g_after;
        m_lat    = 1;
        m_busy   = busy ? 1 : 0;
        while (!done && m_lat < 3000) begin
            @(negedge clk);
            m_lat++;
            if (busy) m_busy++;
        end
        m_cnt   = count;
        m_ovf   = ovf;
        m_cnt_s = count_s;
        m_ovf_s = ovf_s;
        @(negedge clk);
        m_post_done = done;
        m_post_busy = busy;
    endtask

    initial begin
        int exp_lat;
        int n, ndone, done_at;

        //           g  g_after half lo   hi   ovf cs  os
        vecs[0] = '{4'd0, 4'd0,  4,   2,   2,  0,  2,  0};
        vecs[1] = '{4'd6, 4'd6,  5, 101, 103,  0, 15,  1};
        vecs[2] = '{4'd0, 4'd0,  0,   0,   0,  0,  0,  0};
        vecs[3] = '{4'd1, 4'd1,  2,   8,   8,  0,  8,  0};
        vecs[4] = '{4'd2, 4'd2,  2,  16,  16,  0, 15,  1};
        vecs[5] = '{4'd0, 4'd15, 4,   2,   2,  0,  2,  0};
        vecs[6] = '{4'd3, 4'd3,  8,   8,   8,  0,  8,  0};

        rst      = 1'b1;
        start    = 1'b0;
        gate_sel = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_count", longint'(count), 0, 0);
        chk("reset_ovf",   longint'(ovf),   0, 0);
        chk("reset_done",  longint'(done),  0, 0);
        chk("reset_busy",  longint'(busy),  0, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            set_ro(vecs[i].half);
            run_meas(vecs[i].g, vecs[i].g_after, 1'b0);
            exp_lat = 3 + (1 << (int'(vecs[i].g) + 4)) + 1;
            chk($sformatf("v%0d_latency", i), m_lat, exp_lat, exp_lat);
            chk($sformatf("v%0d_busy_cycles", i), m_busy, exp_lat, exp_lat);
            chk($sformatf("v%0d_count", i), longint'(m_cnt), vecs[i].lo, vecs[i].hi);
            chk($sformatf("v%0d_ovf", i), longint'(m_ovf), vecs[i].ovf, vecs[i].ovf);
            chk($sformatf("v%0d_count_w4", i), longint'(m_cnt_s), vecs[i].cs, vecs[i].cs);
            chk($sformatf("v%0d_ovf_w4", i), longint'(m_ovf_s), vecs[i].os, vecs[i].os);
            chk($sformatf("v%0d_done_one_cycle", i), longint'(m_post_done), 0, 0);
            chk($sformatf("v%0d_idle_after", i), longint'(m_post_busy), 0, 0);
        end

        // Results hold while idle
        repeat (20) @(negedge clk);
        chk("hold_count", longint'(count), 8, 8);

        // start re-pulsed in GATE and in the DONE cycle: both ignored
        set_ro(4);
        @(negedge clk);
        start    = 1'b1;
        gate_sel = 4'd0;
        @(negedge clk);
        start   = 1'b0;
        n       = 1;
        ndone   = 0;
        done_at = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (done) begin
                ndone++;
                done_at = n;
                start   = 1'b1;
            end else if (n == 8) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("repulse_done_count", ndone, 1, 1);
        chk("repulse_done_at", done_at, 20, 20);
        chk("repulse_idle_end", longint'(busy), 0, 0);
        chk("repulse_count", longint'(count), 2, 2);

        // Reset mid-GATE aborts immediately; start in the first cycle after release is taken
        set_ro(5);
        @(negedge clk);
        start    = 1'b1;
        gate_sel = 4'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        chk("pre_rst_busy", longint'(busy), 1, 1);
        rst = 1'b1;
        #1;
        chk("rst_busy",  longint'(busy),  0, 0);
        chk("rst_count", longint'(count), 0, 0);
        chk("rst_done",  longint'(done),  0, 0);
        chk("rst_ovf_w4", longint'(ovf_s), 0, 0);
        set_ro(4);
        run_meas(4'd0, 4'd0, 1'b1);
        chk("fresh_latency", m_lat, 20, 20);
        chk("fresh_count", longint'(m_cnt), 2, 2);
        chk("fresh_ovf", longint'(m_ovf), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
